// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states, datapath widths and a 3:2 carry-save helper for the multiplier controller
package mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  localparam int MUL_W = 8;
  localparam int PROD_W = 16;
  // returns {carry<<1, sum}; the bit shifted out of the top never matters because the final product fits PROD_W
  function automatic logic [2*PROD_W-1:0] csa(input logic [PROD_W-1:0] x, input logic [PROD_W-1:0] y, input logic [PROD_W-1:0] z);
    return {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
  endfunction
endpackage

// File: rtl/mul_share_ctrl_if.sv
// mul_share_ctrl_if: requester operand channel and product response channel of the shared multiplier
interface mul_share_ctrl_if #(parameter int NUM_REQ = 4, parameter int ID_W = 2, parameter int CNT_W = 16);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [15:0] rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic busy;
  logic [CNT_W-1:0] op_count;
  modport master(output req_valid, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count);
  modport slave(input req_valid, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count);
endinterface

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first active request at or after i_ptr
module rr_arbiter #(parameter int NUM_REQ = 4, parameter int ID_W = 2) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);
  logic [ID_W-1:0] w_j;
  // scanning from the farthest offset down lets the nearest active request overwrite the rest
  always_comb begin
    w_j = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_j]) begin
        o_idx = w_j;
        o_any = 1'b1;
      end
    end
    o_gnt = o_any ? NUM_REQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/wallace_mul_8bit.sv
// wallace_mul_8bit: combinational 8x8 unsigned multiplier, partial products reduced 8->6->4->3->2 by carry-save rows
module wallace_mul_8bit import mul_pkg::*; (
  input  logic [MUL_W-1:0]  i_a,
  input  logic [MUL_W-1:0]  i_b,
  output logic [PROD_W-1:0] o_p
);
  logic [PROD_W-1:0] w_pp [MUL_W];
  logic [PROD_W-1:0] w_l1 [6];
  logic [PROD_W-1:0] w_l2 [4];
  logic [PROD_W-1:0] w_l3 [3];
  logic [PROD_W-1:0] w_l4 [2];
  for (genvar i = 0; i < MUL_W; i++) begin : g_pp
    assign w_pp[i] = PROD_W'(i_a & {MUL_W{i_b[i]}}) << i;
  end
  assign {w_l1[1], w_l1[0]} = csa(w_pp[0], w_pp[1], w_pp[2]);
  assign {w_l1[3], w_l1[2]} = csa(w_pp[3], w_pp[4], w_pp[5]);
  assign w_l1[4] = w_pp[6];
  assign w_l1[5] = w_pp[7];
  assign {w_l2[1], w_l2[0]} = csa(w_l1[0], w_l1[1], w_l1[2]);
  assign {w_l2[3], w_l2[2]} = csa(w_l1[3], w_l1[4], w_l1[5]);
  assign {w_l3[1], w_l3[0]} = csa(w_l2[0], w_l2[1], w_l2[2]);
  assign w_l3[2] = w_l2[3];
  assign {w_l4[1], w_l4[0]} = csa(w_l3[0], w_l3[1], w_l3[2]);
  assign o_p = w_l4[0] + w_l4[1];
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one Wallace multiplier between NUM_REQ requesters with round-robin grants and an ID-tagged response
module mul_share_ctrl import mul_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst_n,
  mul_share_ctrl_if.slave bus
);
  state_t r_state;
  logic [ID_W-1:0] r_ptr, r_op_id, r_rsp_id, w_idx;
  logic [MUL_W-1:0] r_op_a, r_op_b;
  logic [PROD_W-1:0] r_prod, w_prod;
  logic [CNT_W-1:0] r_cnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic w_any, w_acc, w_opp, w_take;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (.i_req(bus.req_valid), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_idx(w_idx), .o_any(w_any));
  wallace_mul_8bit u_mul (.i_a(r_op_a), .i_b(r_op_b), .o_p(w_prod));
  assign w_acc = r_state == RESP && bus.rsp_ready;
  assign w_opp = r_state == IDLE || w_acc;
  assign w_take = w_opp && w_any;
  assign bus.req_ready = w_opp ? w_gnt : '0;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_data = r_prod;
  assign bus.rsp_id = r_rsp_id;
  assign bus.busy = r_state != IDLE;
  assign bus.op_count = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_op_id <= '0;
      r_rsp_id <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_prod <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_take ? CALC : r_state == CALC ? RESP : w_acc ? IDLE : r_state;
      if (w_take) begin
        r_op_a <= bus.req_a[MUL_W*w_idx +: MUL_W];
        r_op_b <= bus.req_b[MUL_W*w_idx +: MUL_W];
        r_op_id <= w_idx;
        r_ptr <= w_idx == ID_W'(NUM_REQ - 1) ? '0 : w_idx + 1'b1;
      end
      if (r_state == CALC) begin
        r_prod <= w_prod;
        r_rsp_id <= r_op_id;
      end
      if (w_acc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed and randomized checks of the shared multiplier controller
module tb_mul_share_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  mul_share_ctrl_if #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) b0();
  mul_share_ctrl_if #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) b1();
  mul_share_ctrl #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b0));
  mul_share_ctrl #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    b0.req_valid = '0; b0.req_a = '0; b0.req_b = '0; b0.rsp_ready = 1'b0;
    b1.req_valid = '0; b1.req_a = '0; b1.req_b = '0; b1.rsp_ready = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (b0.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", b0.rsp_valid); end
    checks++; if (b0.rsp_data !== 16'h0) begin errs++; $display("FAIL reset_rsp_data got %h want 0000", b0.rsp_data); end
    checks++; if (b0.rsp_id !== 2'd0) begin errs++; $display("FAIL reset_rsp_id got %0d want 0", b0.rsp_id); end
    checks++; if (b0.op_count !== 16'd0) begin errs++; $display("FAIL reset_op_count got %0d want 0", b0.op_count); end
    checks++; if (b0.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", b0.busy); end
    checks++; if (b0.req_ready !== 4'b0000) begin errs++; $display("FAIL reset_req_ready got %b want 0000", b0.req_ready); end
    step(2);
    checks++; if (b0.busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", b0.busy); end
    b0.req_valid = 4'b0001; b0.req_a[7:0] = 8'd2; b0.req_b[7:0] = 8'd3;
    step();
    b0.req_valid = '0;
    step();
    checks++; if (b0.rsp_valid !== 1'b1) begin errs++; $display("FAIL resp_before_reset got %b want 1", b0.rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b0.rsp_valid !== 1'b0) begin errs++; $display("FAIL async_reset_rsp_valid got %b want 0", b0.rsp_valid); end
    checks++; if (b0.busy !== 1'b0) begin errs++; $display("FAIL async_reset_busy got %b want 0", b0.busy); end
    checks++; if (b0.op_count !== 16'd0) begin errs++; $display("FAIL async_reset_op_count got %0d want 0", b0.op_count); end
    checks++; if (b0.rsp_data !== 16'h0) begin errs++; $display("FAIL async_reset_rsp_data got %h want 0000", b0.rsp_data); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    b0.req_valid = 4'b0001; b0.req_a[7:0] = 8'hFF; b0.req_b[7:0] = 8'hFF; b0.rsp_ready = 1'b1;
    #1;
    checks++; if (b0.req_ready !== 4'b0001) begin errs++; $display("FAIL single_grant got %b want 0001", b0.req_ready); end
    step();
    b0.req_valid = '0;
    checks++; if (b0.rsp_valid !== 1'b0) begin errs++; $display("FAIL single_calc_valid got %b want 0", b0.rsp_valid); end
    checks++; if (b0.busy !== 1'b1) begin errs++; $display("FAIL single_calc_busy got %b want 1", b0.busy); end
    step();
    checks++; if (b0.rsp_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", b0.rsp_valid); end
    checks++; if (b0.rsp_data !== 16'hFE01) begin errs++; $display("FAIL single_data got %h want fe01", b0.rsp_data); end
    checks++; if (b0.rsp_id !== 2'd0) begin errs++; $display("FAIL single_id got %0d want 0", b0.rsp_id); end
    step();
    checks++; if (b0.op_count !== 16'd1) begin errs++; $display("FAIL single_count got %0d want 1", b0.op_count); end
    checks++; if (b0.rsp_valid !== 1'b0) begin errs++; $display("FAIL single_drop got %b want 0", b0.rsp_valid); end
    checks++; if (b0.busy !== 1'b0) begin errs++; $display("FAIL single_idle got %b want 0", b0.busy); end
  endtask

  task automatic test_round_robin;
    logic [15:0] exp_p [4];
    exp_p = '{16'h0010, 16'h0040, 16'h0090, 16'h0100};
    do_reset();
    b0.rsp_ready = 1'b1;
    b0.req_valid = 4'b1111;
    b0.req_a = {8'h40, 8'h30, 8'h20, 8'h10};
    b0.req_b = {8'h04, 8'h03, 8'h02, 8'h01};
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++; if (b0.req_ready !== 4'(1 << (n % 4))) begin errs++; $display("FAIL rr_grant%0d got %b want %b", n, b0.req_ready, 4'(1 << (n % 4))); end
      if (n > 0) begin
        checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_data !== exp_p[(n-1)%4] || b0.rsp_id !== 2'((n-1)%4))
          begin errs++; $display("FAIL rr_rsp%0d got v=%b d=%h id=%0d want v=1 d=%h id=%0d", n, b0.rsp_valid, b0.rsp_data, b0.rsp_id, exp_p[(n-1)%4], (n-1)%4); end
      end
      step();
      checks++; if (b0.req_ready !== 4'b0000) begin errs++; $display("FAIL rr_calc_ready%0d got %b want 0000", n, b0.req_ready); end
      step();
    end
    b0.req_valid = '0;
    checks++; if (b0.rsp_data !== 16'h0010 || b0.rsp_id !== 2'd0) begin errs++; $display("FAIL rr_wrap got d=%h id=%0d want d=0010 id=0", b0.rsp_data, b0.rsp_id); end
    step();
  endtask

  task automatic test_back_pressure;
    do_reset();
    b0.req_valid = 4'b0001; b0.req_a[7:0] = 8'd3; b0.req_b[7:0] = 8'd5;
    step();
    b0.req_valid = 4'b0010; b0.req_a[15:8] = 8'd7; b0.req_b[15:8] = 8'd9;
    step();
    for (int n = 0; n < 5; n++) begin
      checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_data !== 16'd15 || b0.rsp_id !== 2'd0 || b0.req_ready !== 4'b0000)
        begin errs++; $display("FAIL bp_hold%0d got v=%b d=%h id=%0d rdy=%b want v=1 d=000f id=0 rdy=0000", n, b0.rsp_valid, b0.rsp_data, b0.rsp_id, b0.req_ready); end
      step();
    end
    b0.rsp_ready = 1'b1;
    #1;
    checks++; if (b0.req_ready !== 4'b0010) begin errs++; $display("FAIL bp_release_grant got %b want 0010", b0.req_ready); end
    step();
    b0.req_valid = '0;
    checks++; if (b0.op_count !== 16'd1) begin errs++; $display("FAIL bp_count got %0d want 1", b0.op_count); end
    step();
    checks++; if (b0.rsp_data !== 16'h003F || b0.rsp_id !== 2'd1) begin errs++; $display("FAIL bp_second got d=%h id=%0d want d=003f id=1", b0.rsp_data, b0.rsp_id); end
    step();
  endtask

  task automatic test_edges;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [15:0] vp [4];
    va = '{8'h00, 8'h80, 8'h01, 8'h0F};
    vb = '{8'hAB, 8'h02, 8'hFF, 8'h0F};
    vp = '{16'h0000, 16'h0100, 16'h00FF, 16'h00E1};
    do_reset();
    b0.rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      b0.req_valid = 4'b0100; b0.req_a[23:16] = va[n]; b0.req_b[23:16] = vb[n];
      step();
      b0.req_valid = '0; b0.req_a[23:16] = ~va[n]; b0.req_b[23:16] = 8'h5A;
      step();
      checks++; if (b0.rsp_data !== vp[n] || b0.rsp_id !== 2'd2) begin errs++; $display("FAIL edge%0d got d=%h id=%0d want d=%h id=2", n, b0.rsp_data, b0.rsp_id, vp[n]); end
      step();
    end
  endtask

  task automatic test_saturation;
    int resp = 0;
    int exp_c;
    do_reset();
    b1.req_valid = 4'b0001; b1.req_a[7:0] = 8'd1; b1.req_b[7:0] = 8'd1; b1.rsp_ready = 1'b1;
    for (int c = 0; c < 46; c++) begin
      if (b1.rsp_valid === 1'b1) resp++;
      if (resp >= 20) b1.req_valid = '0;
      step();
      exp_c = resp > 15 ? 15 : resp;
      checks++; if (b1.op_count !== 4'(exp_c)) begin errs++; $display("FAIL sat_count c=%0d got %0d want %0d", c, b1.op_count, exp_c); end
    end
    checks++; if (resp < 20) begin errs++; $display("FAIL sat_responses got %0d want >=20", resp); end
    checks++; if (b1.op_count !== 4'hF) begin errs++; $display("FAIL sat_final got %h want f", b1.op_count); end
  endtask

  task automatic test_random;
    logic [17:0] q [$];
    logic [17:0] e;
    logic [1:0] mp = 2'd0;
    logic [3:0] expg;
    logic [1:0] g;
    logic opp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      b0.req_valid = 4'($urandom);
      b0.req_a = $urandom;
      b0.req_b = $urandom;
      b0.rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      opp = b0.busy === 1'b0 || (b0.rsp_valid === 1'b1 && b0.rsp_ready);
      expg = '0;
      g = '0;
      for (int k = 3; k >= 0; k--)
        if (opp && b0.req_valid[2'(mp + 2'(k))]) begin
          g = 2'(mp + 2'(k));
          expg = 4'(1 << g);
        end
      checks++; if (b0.req_ready !== expg) begin errs++; $display("FAIL rand_grant c=%0d got %b want %b", c, b0.req_ready, expg); end
      if (b0.rsp_valid === 1'b1 && b0.rsp_ready) begin
        if (q.size() == 0) begin
          checks++; errs++; $display("FAIL rand_unexpected c=%0d got d=%h want no response", c, b0.rsp_data);
        end else begin
          e = q.pop_front();
          checks++; if ({b0.rsp_id, b0.rsp_data} !== e) begin errs++; $display("FAIL rand_rsp c=%0d got id=%0d d=%h want id=%0d d=%h", c, b0.rsp_id, b0.rsp_data, e[17:16], e[15:0]); end
        end
      end
      if (expg != 0) begin
        q.push_back({g, 16'(b0.req_a[8*g +: 8]) * 16'(b0.req_b[8*g +: 8])});
        mp = g + 2'd1;
      end
      step();
    end
    b0.req_valid = '0;
    b0.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (b0.rsp_valid === 1'b1 && q.size() != 0) begin
        e = q.pop_front();
        checks++; if ({b0.rsp_id, b0.rsp_data} !== e) begin errs++; $display("FAIL rand_drain got id=%0d d=%h want id=%0d d=%h", b0.rsp_id, b0.rsp_data, e[17:16], e[15:0]); end
      end
      step();
    end
    checks++; if (q.size() != 0) begin errs++; $display("FAIL rand_pending got %0d want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_edges();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
